// File: rtl/ysyx_24070016_regfile_sb_if.sv
// Bus between issue/writeback logic (master) and the scoreboarded register file (slave).
// Packed read ports: port i uses raddr[i*ADDR_WIDTH +: ADDR_WIDTH] / rdata[i*DATA_WIDTH +: DATA_WIDTH].
interface ysyx_24070016_regfile_sb_if #(
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NR_RPORTS  = 2
);
   logic [NR_RPORTS*ADDR_WIDTH-1:0] raddr;
   logic [NR_RPORTS*DATA_WIDTH-1:0] rdata;
   logic [NR_RPORTS-1:0]            rbusy;
   logic                            wen;
   logic [ADDR_WIDTH-1:0]           waddr;
   logic [DATA_WIDTH-1:0]           wdata;
   logic                            issue_valid;
   logic [ADDR_WIDTH-1:0]           issue_rd;
   logic                            issue_ready;
   logic                            sb_err;

   modport master (
      output raddr, wen, waddr, wdata, issue_valid, issue_rd,
      input  rdata, rbusy, issue_ready, sb_err
   );

   modport slave (
      input  raddr, wen, waddr, wdata, issue_valid, issue_rd,
      output rdata, rbusy, issue_ready, sb_err
   );
endinterface

// File: rtl/ysyx_24070016_regfile_sb.sv
// N-read / 1-write GPR file with same-cycle write bypass and a per-register
// pending-write scoreboard (issue reserves rd, writeback commits it).
// x0 and addresses >= NR_REGS read 0 and are never written or counted.
module ysyx_24070016_regfile_sb #(
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NR_REGS    = 16,
   parameter int unsigned NR_RPORTS  = 2,
   parameter int unsigned CNT_WIDTH  = 2
) (
   input logic                       clk,
   input logic                       rst,
   ysyx_24070016_regfile_sb_if.slave bus
);

   localparam int unsigned IDX_W = (NR_REGS > 1) ? $clog2(NR_REGS) : 1;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   logic [DATA_WIDTH-1:0] regs_q [NR_REGS];
   logic [CNT_WIDTH-1:0]  cnt_q  [NR_REGS];
   logic [CNT_WIDTH-1:0]  cnt_d  [NR_REGS];
   logic                  sb_err_q, sb_err_d;

   logic                          wr_ok;
   logic                          iss_fire;
   logic                          issue_ready_c;
   logic [NR_RPORTS*DATA_WIDTH-1:0] rdata_c;
   logic [NR_RPORTS-1:0]          rbusy_c;

   function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
      return (a != '0) && (32'(a) < NR_REGS);
   endfunction

   function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_WIDTH-1:0] a);
      return a[IDX_W-1:0];
   endfunction

   // Handshake decode: commit validity, issue readiness and issue firing
   always_comb begin
      wr_ok         = bus.wen && addr_ok(bus.waddr);
      issue_ready_c = 1'b1;
      if (addr_ok(bus.issue_rd) && (cnt_q[idx_of(bus.issue_rd)] == CNT_MAX)
          && !(wr_ok && (bus.waddr == bus.issue_rd)))
         issue_ready_c = 1'b0;
      iss_fire = bus.issue_valid && issue_ready_c && addr_ok(bus.issue_rd);
   end

   // Scoreboard next state; issue+commit on one register cancel out
   always_comb begin
      logic inc, dec;
      inc      = 1'b0;
      dec      = 1'b0;
      cnt_d    = cnt_q;
      sb_err_d = sb_err_q;
      for (int unsigned r = 1; r < NR_REGS; r++) begin
         inc = iss_fire && (32'(bus.issue_rd) == r);
         dec = wr_ok && (32'(bus.waddr) == r);
         if (inc && !dec) begin
            cnt_d[r] = cnt_q[r] + 1'b1;
         end else if (dec && !inc) begin
            if (cnt_q[r] == '0) sb_err_d = 1'b1;
            else                cnt_d[r] = cnt_q[r] - 1'b1;
         end
      end
   end

   // Combinational read ports with writeback bypass
   always_comb begin
      logic [ADDR_WIDTH-1:0] ra;
      ra      = '0;
      rdata_c = '0;
      rbusy_c = '0;
      for (int unsigned i = 0; i < NR_RPORTS; i++) begin
         ra = bus.raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
         if (addr_ok(ra)) begin
            rbusy_c[i] = (cnt_q[idx_of(ra)] != '0);
            if (wr_ok && (bus.waddr == ra))
               rdata_c[i*DATA_WIDTH +: DATA_WIDTH] = bus.wdata;
            else
               rdata_c[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[idx_of(ra)];
         end
      end
   end

   assign bus.rdata       = rdata_c;
   assign bus.rbusy       = rbusy_c;
   assign bus.issue_ready = issue_ready_c;
   assign bus.sb_err      = sb_err_q;

   // State update; reset discards data, pending counts and the error flag
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned r = 0; r < NR_REGS; r++) begin
            regs_q[r] <= '0;
            cnt_q[r]  <= '0;
         end
         sb_err_q <= 1'b0;
      end else begin
         if (wr_ok) regs_q[idx_of(bus.waddr)] <= bus.wdata;
         cnt_q    <= cnt_d;
         sb_err_q <= sb_err_d;
      end
   end

endmodule

// File: doc/ysyx_24070016_regfile_sb.md
Name: ysyx_24070016_regfile_sb

Overview:
- Parametrised successor to the core GPR file: N-read / 1-write register array with synchronous reset, same-cycle write-to-read bypass, and an integrated per-register pending-write scoreboard.
- Sits between decode/issue (read operands, reserve rd) and writeback (commit rd) in the pipelined NPC.
- Supports RV32E (16 regs) or RV32I (32 regs) through NR_REGS.

Parameters:
- ADDR_WIDTH, 5, register address width.
- DATA_WIDTH, 32, register data width.
- NR_REGS, 16, number of implemented registers (16 or 32). Must be ≤ 2**ADDR_WIDTH.
- NR_RPORTS, 2, number of read ports (1..4).
- CNT_WIDTH, 2, width of each per-register pending-write counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- raddr  in  NR_RPORTS*ADDR_WIDTH  packed read addresses; port i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- rdata  out  NR_RPORTS*DATA_WIDTH  packed read data.
- rbusy  out  NR_RPORTS  high when port i's register has a nonzero pending count.
- wen  in  1  writeback valid.
- waddr  in  ADDR_WIDTH  writeback register.
- wdata  in  DATA_WIDTH  writeback data.
- issue_valid  in  1  request to reserve issue_rd.
- issue_rd  in  ADDR_WIDTH  destination register to reserve.
- issue_ready  out  1  reservation can be accepted this cycle.
- sb_err  out  1  sticky scoreboard underflow flag.

Behaviour:
- Storage: NR_REGS x DATA_WIDTH flops.
  - rst clears all registers, all counters and sb_err on the next edge.
  - After reset every rdata reads 0, every rbusy is 0, and issue_ready is 1.
- Write:
  - On a clock edge with wen=1, 0<waddr<NR_REGS and rst=0, the register takes wdata.
  - Writes to x0 or to waddr≥NR_REGS are dropped.
- Read: combinational, 0-cycle latency.
  - raddr=0 or raddr≥NR_REGS returns 0, with rbusy=0.
  - Bypass: if wen=1 and raddr==waddr (nonzero and in range), rdata returns wdata in the same cycle.
- Scoreboard: one CNT_WIDTH counter cnt[r] per register r in 1..NR_REGS-1.
  - Define max = 2**CNT_WIDTH-1.
  - Issue fires when issue_valid && issue_ready, issue_rd≠0 and issue_rd<NR_REGS. It increments cnt[issue_rd].
  - An issue to x0 or an out-of-range register is accepted with no effect.
  - A commit is wen=1 with a valid waddr. It decrements cnt[waddr].
  - Issue and commit to the same register in one cycle: the counter is unchanged.
  - Commit with cnt[waddr]=0: the data is still written, the counter stays 0, and sb_err is set (sticky until rst).
  - Commit to the same register in the same cycle as an issue that brings it to 0 is not an underflow (net unchanged rule applies).
- issue_ready:
  - Equals 0 when cnt[issue_rd]==max and there is no same-cycle commit to issue_rd. Otherwise 1.
  - Combinational from issue_rd, wen and waddr.
  - Issue is a valid/ready handshake: the requester holds issue_valid and issue_rd until ready.
- rbusy[i]:
  - Equals (cnt[raddr_i]≠0), combinational.
  - It does not account for a same-cycle commit. The bypassed data is correct but rbusy may still read 1 if the count stays ≥1.
- Reset mid-operation: rst wins over any simultaneous wen or issue. Pending counts are discarded.
- Out-of-range addresses never index the array; there is no X propagation.

Optional Feature:
- Macro: YSYX_24070016_RF_DPI_EN.
- When defined:
  - Import DPI-C set_gpr_ptr(input logic [DATA_WIDTH-1:0] r[]) and call it once in an initial block with the storage array, so the simulator and difftest read GPRs directly.
  - Additionally import DPI-C rf_sb_err(), called once on the edge where sb_err rises.
- When undefined: no DPI imports and no initial blocks. The block is fully synthesizable, with identical cycle behaviour.

Test Plan:
- Reset/read: assert rst 1 cycle, then read all addresses 0..31 with NR_REGS=16 -> every rdata=0, rbusy=0, issue_ready=1, sb_err=0.
- Write/bypass:
  - Apply wen=1, waddr=5, wdata=0xDEADBEEF with raddr0=5 in the same cycle -> rdata0=0xDEADBEEF that cycle and on the following cycle.
  - Write to x0 and to waddr=20 (NR_REGS=16) -> reads of 0 and 20 stay 0.
- Scoreboard saturation (CNT_WIDTH=2):
  - Issue rd=3 four times with no commit -> after 3 accepts cnt=3 and issue_ready=0 on the 4th.
  - Assert commit to 3 in the same cycle as the 4th issue -> issue_ready=1, cnt stays 3.
- Simultaneous issue+commit: cnt[7]=1; issue rd=7 and commit 7 in the same cycle -> cnt[7]=1, rbusy for 7 stays 1, data written.
- Underflow: commit waddr=9 with cnt[9]=0 -> register 9 is written, cnt[9]=0, sb_err=1 and held; rst -> sb_err=0.
- Reset mid-operation:
  - Set cnt[2]=2 and issue rd=2 with rst=1 in the same cycle -> next cycle cnt[2]=0, reg2=0, rbusy=0.
  - Repeat the directed cases with NR_REGS=32 and NR_RPORTS=3.
